// File: rtl/seg7_scan_driver.sv
// Debounced half-select plus 4-digit common-anode hex scanner for the 32-bit debug word.
// Optional leading-zero blanking is enabled by defining SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_driver #(
   parameter int REFRESH_DIV     = 50000,
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic [31:0] dataIn,
   input  logic        selButton,
   output logic [6:0]  disp7Seg,
   output logic [3:0]  selDisp,
   output logic        halfSel
);
   localparam int RCW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int DCW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [RCW-1:0] REFRESH_LAST  = RCW'(REFRESH_DIV - 1);
   localparam logic [DCW-1:0] DEBOUNCE_LAST = DCW'(DEBOUNCE_CYCLES - 1);

   logic           btn_meta_q, btn_sync_q;
   logic           btn_stable_q, btn_stable_d;
   logic [DCW-1:0] deb_cnt_q, deb_cnt_d;
   logic           half_sel_q, half_sel_d;
   logic [RCW-1:0] refresh_cnt_q, refresh_cnt_d;
   logic [1:0]     digit_idx_q, digit_idx_d;
   logic [15:0]    snapshot_q, snapshot_d;
   logic [3:0]     sel_disp_q, sel_disp_d;
   logic [6:0]     seg_q, seg_d;
   logic           wrap;
   logic           blank;
   logic [3:0]     nibble [4];

   function automatic logic [6:0] hex_glyph(input logic [3:0] v);
      case (v)
         4'h0: hex_glyph = 7'h40;
         4'h1: hex_glyph = 7'h79;
         4'h2: hex_glyph = 7'h24;
         4'h3: hex_glyph = 7'h30;
         4'h4: hex_glyph = 7'h19;
         4'h5: hex_glyph = 7'h12;
         4'h6: hex_glyph = 7'h02;
         4'h7: hex_glyph = 7'h78;
         4'h8: hex_glyph = 7'h00;
         4'h9: hex_glyph = 7'h10;
         4'hA: hex_glyph = 7'h08;
         4'hB: hex_glyph = 7'h03;
         4'hC: hex_glyph = 7'h46;
         4'hD: hex_glyph = 7'h21;
         4'hE: hex_glyph = 7'h06;
         default: hex_glyph = 7'h0E;
      endcase
   endfunction

   // Debounce: a new level must persist DEBOUNCE_CYCLES cycles; only accepted presses toggle the half.
   always_comb begin
      btn_stable_d = btn_stable_q;
      deb_cnt_d    = deb_cnt_q;
      half_sel_d   = half_sel_q;
      if (btn_sync_q == btn_stable_q) begin
         deb_cnt_d = '0;
      end else if (deb_cnt_q == DEBOUNCE_LAST) begin
         btn_stable_d = btn_sync_q;
         deb_cnt_d    = '0;
         if (btn_sync_q)
            half_sel_d = ~half_sel_q;
      end else begin
         deb_cnt_d = deb_cnt_q + DCW'(1);
      end
   end

   // Snapshot uses the pre-toggle half so a press on a frame boundary lands in the next frame.
   always_comb begin
      wrap          = (refresh_cnt_q == REFRESH_LAST);
      refresh_cnt_d = wrap ? '0 : refresh_cnt_q + RCW'(1);
      digit_idx_d   = wrap ? digit_idx_q + 2'd1 : digit_idx_q;
      snapshot_d    = snapshot_q;
      if (wrap && digit_idx_q == 2'd3)
         snapshot_d = half_sel_q ? dataIn[31:16] : dataIn[15:0];
   end

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_nibble
         assign nibble[gi] = snapshot_d[4*gi +: 4];
      end
   endgenerate

`ifdef SEG7_LEADING_ZERO_BLANK_EN
   always_comb begin
      blank = 1'b0;
      case (digit_idx_d)
         2'd1:    blank = (snapshot_d[15:4] == 12'h000);
         2'd2:    blank = (snapshot_d[15:8] == 8'h00);
         2'd3:    blank = (snapshot_d[15:12] == 4'h0);
         default: blank = 1'b0;
      endcase
   end
`else
   assign blank = 1'b0;
`endif

   always_comb begin
      sel_disp_d = ~(4'b0001 << digit_idx_d);
      seg_d      = blank ? 7'h7F : hex_glyph(nibble[digit_idx_d]);
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         btn_meta_q    <= 1'b0;
         btn_sync_q    <= 1'b0;
         btn_stable_q  <= 1'b0;
         deb_cnt_q     <= '0;
         half_sel_q    <= 1'b0;
         refresh_cnt_q <= '0;
         digit_idx_q   <= 2'd0;
         snapshot_q    <= 16'h0000;
         sel_disp_q    <= 4'b1110;
         seg_q         <= 7'b1000000;
      end else begin
         btn_meta_q    <= selButton;
         btn_sync_q    <= btn_meta_q;
         btn_stable_q  <= btn_stable_d;
         deb_cnt_q     <= deb_cnt_d;
         half_sel_q    <= half_sel_d;
         refresh_cnt_q <= refresh_cnt_d;
         digit_idx_q   <= digit_idx_d;
         snapshot_q    <= snapshot_d;
         sel_disp_q    <= sel_disp_d;
         seg_q         <= seg_d;
      end
   end

   assign disp7Seg = seg_q;
   assign selDisp  = sel_disp_q;
   assign halfSel  = half_sel_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: expected digits are queued per frame and checked on each digit change.
module tb_seg7_scan_driver;
   localparam int REFRESH_DIV     = 4;
   localparam int DEBOUNCE_CYCLES = 8;

   logic        Clk;
   logic        Rst;
   logic [31:0] dataIn;
   logic        selButton;
   logic [6:0]  disp7Seg;
   logic [3:0]  selDisp;
   logic        halfSel;

   int n_vectors     = 0;
   int n_miscompares = 0;

   logic [10:0] sb_q [$];
   int          gap_cnt;
   logic [3:0]  prev_sel;

   seg7_scan_driver #(
      .REFRESH_DIV     (REFRESH_DIV),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) dut (
      .Clk       (Clk),
      .Rst       (Rst),
      .dataIn    (dataIn),
      .selButton (selButton),
      .disp7Seg  (disp7Seg),
      .selDisp   (selDisp),
      .halfSel   (halfSel)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   function automatic logic [6:0] exp_glyph(input logic [15:0] snap, input int d);
      logic [3:0]  nib;
      logic [15:0] upper;
      logic [6:0]  g;
      nib   = 4'((snap >> (4 * d)) & 16'h000F);
      upper = snap >> (4 * d);
      case (nib)
         4'h0: g = 7'h40;  4'h1: g = 7'h79;  4'h2: g = 7'h24;  4'h3: g = 7'h30;
         4'h4: g = 7'h19;  4'h5: g = 7'h12;  4'h6: g = 7'h02;  4'h7: g = 7'h78;
         4'h8: g = 7'h00;  4'h9: g = 7'h10;  4'hA: g = 7'h08;  4'hB: g = 7'h03;
         4'hC: g = 7'h46;  4'hD: g = 7'h21;  4'hE: g = 7'h06;  default: g = 7'h0E;
      endcase
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      if (d != 0 && upper == 16'h0000)
         g = 7'h7F;
`else
      if (upper == 16'hFFFF && d == 99)
         g = 7'h7F;
`endif
      return g;
   endfunction

   task automatic push_frame(input logic [15:0] snap, input int first_digit);
      logic [3:0] sel;
      for (int d = first_digit; d < 4; d++) begin
         sel = ~(4'b0001 << d);
         sb_q.push_back({sel, exp_glyph(snap, d)});
      end
   endtask

   // Monitor: every digit change pops one expected {selDisp, disp7Seg} and checks the dwell time.
   always @(negedge Clk) begin
      logic [10:0] exp_v;
      if (Rst) begin
         gap_cnt  = 0;
         prev_sel = 4'b1110;
      end else begin
         gap_cnt++;
         if (selDisp !== prev_sel) begin
            if (sb_q.size() > 0) begin
               exp_v = sb_q.pop_front();
               n_vectors++;
               if ({selDisp, disp7Seg} !== exp_v) begin
                  n_miscompares++;
                  $display("FAIL scan_digit: got sel=%b seg=%h, expected sel=%b seg=%h",
                           selDisp, disp7Seg, exp_v[10:7], exp_v[6:0]);
               end else
                  $display("ok scan_digit sel=%b seg=%h", selDisp, disp7Seg);
               n_vectors++;
               if (gap_cnt != REFRESH_DIV) begin
                  n_miscompares++;
                  $display("FAIL digit_period: got %0d clocks, expected %0d", gap_cnt, REFRESH_DIV);
               end
            end
            gap_cnt  = 0;
            prev_sel = selDisp;
         end
      end
   end

   task automatic apply_reset();
      @(negedge Clk);
      Rst       = 1'b1;
      selButton = 1'b0;
      sb_q.delete();
      repeat (2) @(negedge Clk);
      #1 Rst = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge Clk);
      n_vectors++;
      if (selDisp !== 4'b1110) begin n_miscompares++; $display("FAIL reset_sel: got %b, expected 1110", selDisp); end
      n_vectors++;
      if (disp7Seg !== 7'h40) begin n_miscompares++; $display("FAIL reset_seg: got %h, expected 40", disp7Seg); end
      n_vectors++;
      if (halfSel !== 1'b0) begin n_miscompares++; $display("FAIL reset_half: got %b, expected 0", halfSel); end
      $display("test_reset sel=%b seg=%h half=%b", selDisp, disp7Seg, halfSel);
   endtask

   task automatic test_scan();
      int t;
      dataIn = 32'h0000_1234;
      apply_reset();
      push_frame(16'h0000, 1);
      push_frame(16'h1234, 0);
      t = 0;
      while (sb_q.size() != 0 && t < 200) begin @(negedge Clk); t++; end
      n_vectors++;
      if (sb_q.size() != 0) begin
         n_miscompares++;
         $display("FAIL scan_drain: %0d entries left, expected 0", sb_q.size());
         sb_q.delete();
      end
   endtask

   task automatic test_half_toggle();
      int t;
      dataIn = 32'hABCD_0000;
      apply_reset();
      push_frame(16'h0000, 1);
      push_frame(16'hABCD, 0);
      selButton = 1'b1;
      repeat (9) @(posedge Clk);
      @(negedge Clk);
      n_vectors++;
      if (halfSel !== 1'b0) begin n_miscompares++; $display("FAIL half_early: got %b, expected 0", halfSel); end
      @(posedge Clk);
      @(negedge Clk);
      n_vectors++;
      if (halfSel !== 1'b1) begin n_miscompares++; $display("FAIL half_toggle: got %b, expected 1", halfSel); end
      $display("test_half_toggle half=%b after 10 clocks", halfSel);
      repeat (10) @(negedge Clk);
      selButton = 1'b0;
      t = 0;
      while (sb_q.size() != 0 && t < 200) begin @(negedge Clk); t++; end
      n_vectors++;
      if (sb_q.size() != 0) begin
         n_miscompares++;
         $display("FAIL half_drain: %0d entries left, expected 0", sb_q.size());
         sb_q.delete();
      end
      repeat (15) @(negedge Clk);
      n_vectors++;
      if (halfSel !== 1'b1) begin n_miscompares++; $display("FAIL half_release: got %b, expected 1", halfSel); end
   endtask

   task automatic test_bounce();
      logic moved;
      dataIn = 32'h0000_0000;
      apply_reset();
      moved = 1'b0;
      for (int p = 0; p < 3; p++) begin
         selButton = 1'b1;
         repeat (5) begin @(negedge Clk); if (halfSel !== 1'b0 || dut.btn_stable_q !== 1'b0) moved = 1'b1; end
         selButton = 1'b0;
         repeat (3) begin @(negedge Clk); if (halfSel !== 1'b0 || dut.btn_stable_q !== 1'b0) moved = 1'b1; end
      end
      repeat (15) begin @(negedge Clk); if (halfSel !== 1'b0 || dut.btn_stable_q !== 1'b0) moved = 1'b1; end
      n_vectors++;
      if (moved !== 1'b0) begin n_miscompares++; $display("FAIL bounce_steady: got moved=%b, expected 0", moved); end
      n_vectors++;
      if (halfSel !== 1'b0) begin n_miscompares++; $display("FAIL bounce_half: got %b, expected 0", halfSel); end
      $display("test_bounce half=%b moved=%b", halfSel, moved);
   endtask

   task automatic test_data_change();
      int t;
      dataIn = 32'h0000_1111;
      apply_reset();
      push_frame(16'h0000, 1);
      push_frame(16'h1111, 0);
      push_frame(16'h2222, 0);
      repeat (22) @(posedge Clk);
      #1 dataIn = 32'h0000_2222;
      t = 0;
      while (sb_q.size() != 0 && t < 200) begin @(negedge Clk); t++; end
      n_vectors++;
      if (sb_q.size() != 0) begin
         n_miscompares++;
         $display("FAIL data_drain: %0d entries left, expected 0", sb_q.size());
         sb_q.delete();
      end
   endtask

   task automatic test_async_reset();
      int t;
      dataIn = 32'h0000_5678;
      apply_reset();
      selButton = 1'b1;
      repeat (20) @(negedge Clk);
      selButton = 1'b0;
      n_vectors++;
      if (halfSel !== 1'b1) begin n_miscompares++; $display("FAIL arst_pre_half: got %b, expected 1", halfSel); end
      t = 0;
      while (selDisp !== 4'b1011 && t < 50) begin @(negedge Clk); t++; end
      n_vectors++;
      if (selDisp !== 4'b1011) begin n_miscompares++; $display("FAIL arst_wait_digit2: got %b, expected 1011", selDisp); end
      #2 Rst = 1'b1;
      #1;
      n_vectors++;
      if (selDisp !== 4'b1110) begin n_miscompares++; $display("FAIL arst_sel: got %b, expected 1110", selDisp); end
      n_vectors++;
      if (disp7Seg !== 7'h40) begin n_miscompares++; $display("FAIL arst_seg: got %h, expected 40", disp7Seg); end
      n_vectors++;
      if (halfSel !== 1'b0) begin n_miscompares++; $display("FAIL arst_half: got %b, expected 0", halfSel); end
      $display("test_async_reset sel=%b seg=%h half=%b", selDisp, disp7Seg, halfSel);
      @(negedge Clk);
      #1 Rst = 1'b0;
      // Partial debounce count must be discarded by a reset in the middle of it.
      selButton = 1'b1;
      repeat (6) @(negedge Clk);
      #2 Rst = 1'b1;
      @(negedge Clk);
      #1 Rst = 1'b0;
      repeat (9) @(posedge Clk);
      @(negedge Clk);
      n_vectors++;
      if (halfSel !== 1'b0) begin n_miscompares++; $display("FAIL arst_deb_discard: got %b, expected 0", halfSel); end
      @(posedge Clk);
      @(negedge Clk);
      n_vectors++;
      if (halfSel !== 1'b1) begin n_miscompares++; $display("FAIL arst_deb_restart: got %b, expected 1", halfSel); end
      selButton = 1'b0;
   endtask

`ifdef SEG7_LEADING_ZERO_BLANK_EN
   task automatic test_blank();
      int t;
      dataIn = 32'h0000_0050;
      apply_reset();
      push_frame(16'h0000, 1);
      push_frame(16'h0050, 0);
      push_frame(16'h0000, 0);
      repeat (20) @(posedge Clk);
      #1 dataIn = 32'h0000_0000;
      t = 0;
      while (sb_q.size() != 0 && t < 200) begin @(negedge Clk); t++; end
      n_vectors++;
      if (sb_q.size() != 0) begin
         n_miscompares++;
         $display("FAIL blank_drain: %0d entries left, expected 0", sb_q.size());
         sb_q.delete();
      end
   endtask
`endif

   initial begin
      Rst       = 1'b1;
      selButton = 1'b0;
      dataIn    = 32'h0000_0000;
      test_reset();
      test_scan();
      test_half_toggle();
      test_bounce();
      test_data_change();
      test_async_reset();
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      test_blank();
`endif
      repeat (2) @(negedge Clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
      $finish;
   end
endmodule
